// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - controller/RAM side bundle of the instruction fetch unit
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int OFF_W   = 8
);
  logic               fetch;
  logic               branch;
  logic               branch_abs;
  logic [ADDR_W-1:0]  target;
  logic [OFF_W-1:0]   offset;
  logic               halt;
  logic               msel;
  logic [ADDR_W-1:0]  data_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               halted;

  // master is everything around the unit: controller FSM, datapath and RAM
  modport master (
    output fetch, branch, branch_abs, target, offset, halt, msel, data_addr, mem_rdata,
    input  mem_addr, mem_rd, ir, ir_valid, pc, busy, halted
  );

  modport slave (
    input  fetch, branch, branch_abs, target, offset, halt, msel, data_addr, mem_rdata,
    output mem_addr, mem_rd, ir, ir_valid, pc, busy, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, memory-address mux and instruction register with latency-configurable fetch
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                OFF_W    = 8,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HALTED
  } state_t;

  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0]  off_ext;

  assign off_ext = ADDR_W'($signed(bus.offset));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.halt) begin
          state_d = S_HALTED;
        end else begin
          // branch and fetch together: the fetch picks up the branched PC on the next cycle
          if (bus.branch) begin
            pc_d = bus.branch_abs ? bus.target : pc_q + off_ext;
          end
          if (bus.fetch) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          ir_d       = bus.mem_rdata;
          pc_d       = pc_q + ADDR_W'(1);
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.busy     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus.halted   = (state_q == S_HALTED);
  assign bus.mem_rd   = (state_q == S_REQ);
  assign bus.mem_addr = ((state_q == S_IDLE) && bus.msel) ? bus.data_addr : pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        lat_reset = 1'b1;
  logic        lat_fetch = 1'b0;
  int          vectors     = 0;
  int          miscompares = 0;
  int          rd_count    = 0;
  logic [7:0]  rd_addr     = 8'h00;
  logic [15:0] ram [0:255];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16), .OFF_W(8)) bus ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .OFF_W(8), .MEM_LAT(1), .RESET_PC(8'h00)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      rd_count = rd_count + 1;
      rd_addr  = bus.mem_addr;
    end
  end

  logic [4:1]       lat_valid, lat_busy, lat_rd, lat_halted;
  logic [4:1][7:0]  lat_pc, lat_addr;
  logic [4:1][15:0] lat_ir;

  for (genvar L = 1; L <= 4; L++) begin : g_lat
    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16), .OFF_W(8)) lbus ();
    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .OFF_W(8), .MEM_LAT(L), .RESET_PC(8'h00)) u_lat (
      .clk   (clk),
      .reset (lat_reset),
      .bus   (lbus.slave)
    );
    assign lbus.fetch      = lat_fetch;
    assign lbus.branch     = 1'b0;
    assign lbus.branch_abs = 1'b0;
    assign lbus.target     = 8'h00;
    assign lbus.offset     = 8'h00;
    assign lbus.halt       = 1'b0;
    assign lbus.msel       = 1'b0;
    assign lbus.data_addr  = 8'h00;
    assign lbus.mem_rdata  = ram[lbus.mem_addr];
    assign lat_valid[L]    = lbus.ir_valid;
    assign lat_busy[L]     = lbus.busy;
    assign lat_rd[L]       = lbus.mem_rd;
    assign lat_halted[L]   = lbus.halted;
    assign lat_pc[L]       = lbus.pc;
    assign lat_addr[L]     = lbus.mem_addr;
    assign lat_ir[L]       = lbus.ir;
  end

  task automatic drive(input logic f, input logic b, input logic ba,
                       input logic [7:0] t, input logic [7:0] o, input logic h);
    @(negedge clk);
    bus.fetch = f; bus.branch = b; bus.branch_abs = ba;
    bus.target = t; bus.offset = o; bus.halt = h;
    @(negedge clk);
    bus.fetch = 1'b0; bus.branch = 1'b0; bus.branch_abs = 1'b0;
    bus.target = 8'h00; bus.offset = 8'h00; bus.halt = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.ir_valid === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0; lat_reset = 1'b0;
    #1;
    vectors++; if (bus.pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h expected 00", bus.pc); end
    vectors++; if (bus.ir !== 16'h0000) begin miscompares++; $display("FAIL reset_ir: got %h expected 0000", bus.ir); end
    vectors++; if ({bus.ir_valid, bus.mem_rd, bus.busy, bus.halted} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0000", {bus.ir_valid, bus.mem_rd, bus.busy, bus.halted}); end
    repeat (2) @(negedge clk);
    reset = 1'b1; lat_reset = 1'b1;
  endtask

  task automatic test_seq_fetch;
    int e;
    rd_count = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_valid(e);
    vectors++; if (e !== 2) begin miscompares++; $display("FAIL seq1_latency: got %0d edges expected 2", e); end
    vectors++; if (bus.ir !== 16'hD105) begin miscompares++; $display("FAIL seq1_ir: got %h expected d105", bus.ir); end
    vectors++; if (bus.pc !== 8'h01) begin miscompares++; $display("FAIL seq1_pc: got %h expected 01", bus.pc); end
    vectors++; if (rd_count !== 1 || rd_addr !== 8'h00) begin miscompares++; $display("FAIL seq1_rd: got %0d reads addr %h expected 1 at 00", rd_count, rd_addr); end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_valid(e);
    vectors++; if (e !== 2) begin miscompares++; $display("FAIL seq2_latency: got %0d edges expected 2", e); end
    vectors++; if (bus.ir !== 16'hD203) begin miscompares++; $display("FAIL seq2_ir: got %h expected d203", bus.ir); end
    vectors++; if (bus.pc !== 8'h02) begin miscompares++; $display("FAIL seq2_pc: got %h expected 02", bus.pc); end
    vectors++; if (rd_count !== 2 || rd_addr !== 8'h01) begin miscompares++; $display("FAIL seq2_rd: got %0d reads addr %h expected 2 at 01", rd_count, rd_addr); end
  endtask

  task automatic test_branch;
    int e;
    int rd0;
    drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0);
    vectors++; if (bus.pc !== 8'h10) begin miscompares++; $display("FAIL br_abs10: got %h expected 10", bus.pc); end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0);
    vectors++; if (bus.pc !== 8'h0E) begin miscompares++; $display("FAIL br_rel_neg: got %h expected 0e", bus.pc); end
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
    vectors++; if (bus.pc !== 8'h00) begin miscompares++; $display("FAIL br_rel_wrap: got %h expected 00", bus.pc); end
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    vectors++; if (bus.pc !== 8'h40) begin miscompares++; $display("FAIL br_abs40: got %h expected 40", bus.pc); end
    drive(1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0);
    rd0 = rd_count;
    drive(1'b1, 1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    wait_valid(e);
    vectors++; if (rd_count !== rd0 + 1 || rd_addr !== 8'h40) begin miscompares++; $display("FAIL br_fetch_rd: got %0d reads addr %h expected 1 at 40", rd_count - rd0, rd_addr); end
    vectors++; if (bus.ir !== 16'hA040) begin miscompares++; $display("FAIL br_fetch_ir: got %h expected a040", bus.ir); end
    vectors++; if (bus.pc !== 8'h41) begin miscompares++; $display("FAIL br_fetch_pc: got %h expected 41", bus.pc); end
  endtask

  task automatic test_busy_ignore;
    int rd0;
    rd0 = rd_count;
    @(negedge clk); bus.fetch = 1'b1;
    @(negedge clk); bus.branch = 1'b1; bus.branch_abs = 1'b1; bus.target = 8'h80; bus.halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.fetch = 1'b0; bus.branch = 1'b0; bus.branch_abs = 1'b0; bus.target = 8'h00; bus.halt = 1'b0;
    #1;
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'hA041) begin miscompares++; $display("FAIL busy_ir: got valid %b ir %h expected 1 a041", bus.ir_valid, bus.ir); end
    vectors++; if (bus.pc !== 8'h42) begin miscompares++; $display("FAIL busy_pc: got %h expected 42", bus.pc); end
    repeat (2) @(negedge clk);
    #1;
    vectors++; if ({bus.busy, bus.halted} !== 2'b00) begin miscompares++; $display("FAIL busy_state: got busy/halted %b expected 00", {bus.busy, bus.halted}); end
    vectors++; if (rd_count !== rd0 + 1 || bus.pc !== 8'h42) begin miscompares++; $display("FAIL busy_once: got %0d reads pc %h expected 1 at 42", rd_count - rd0, bus.pc); end
  endtask

  task automatic test_msel;
    @(negedge clk); bus.msel = 1'b1; bus.data_addr = 8'h22;
    #1;
    vectors++; if (bus.mem_addr !== 8'h22) begin miscompares++; $display("FAIL msel_idle: got %h expected 22", bus.mem_addr); end
    bus.fetch = 1'b1;
    @(negedge clk); bus.fetch = 1'b0;
    #1;
    vectors++; if (bus.mem_addr !== 8'h42 || bus.mem_rd !== 1'b1) begin miscompares++; $display("FAIL msel_req: got addr %h rd %b expected 42 1", bus.mem_addr, bus.mem_rd); end
    @(negedge clk); #1;
    vectors++; if (bus.mem_addr !== 8'h42 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL msel_wait: got addr %h busy %b expected 42 1", bus.mem_addr, bus.busy); end
    @(negedge clk); #1;
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'hA042 || bus.pc !== 8'h43) begin
      miscompares++; $display("FAIL msel_done: got valid %b ir %h pc %h expected 1 a042 43", bus.ir_valid, bus.ir, bus.pc); end
    vectors++; if (bus.mem_addr !== 8'h22) begin miscompares++; $display("FAIL msel_back: got %h expected 22", bus.mem_addr); end
    bus.msel = 1'b0; bus.data_addr = 8'h00;
  endtask

  task automatic test_halt;
    int rd0;
    rd0 = rd_count;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    #1;
    vectors++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL halt_enter: got halted %b busy %b expected 1 0", bus.halted, bus.busy); end
    vectors++; if (bus.pc !== 8'h43 || bus.mem_addr !== 8'h43) begin miscompares++; $display("FAIL halt_pc: got pc %h addr %h expected 43 43", bus.pc, bus.mem_addr); end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'h99, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (bus.halted !== 1'b1 || bus.pc !== 8'h43 || bus.ir !== 16'hA042) begin
      miscompares++; $display("FAIL halt_stuck: got halted %b pc %h ir %h expected 1 43 a042", bus.halted, bus.pc, bus.ir); end
    vectors++; if (rd_count !== rd0) begin miscompares++; $display("FAIL halt_no_rd: got %0d reads expected 0", rd_count - rd0); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.halted !== 1'b0 || bus.pc !== 8'h00 || bus.ir !== 16'h0000) begin
      miscompares++; $display("FAIL halt_reset: got halted %b pc %h ir %h expected 0 00 0000", bus.halted, bus.pc, bus.ir); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_latency;
    int vedge [1:4];
    int bcnt  [1:4];
    int vcnt  [1:4];
    logic addr_bad;
    addr_bad = 1'b0;
    @(negedge clk); lat_fetch = 1'b1;
    @(posedge clk); #1; lat_fetch = 1'b0;
    for (int l = 1; l <= 4; l++) begin
      vedge[l] = 0; vcnt[l] = 0;
      bcnt[l] = (lat_busy[l] === 1'b1) ? 1 : 0;
      if (lat_rd[l] !== 1'b1 || lat_addr[l] !== 8'h00) addr_bad = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      for (int l = 1; l <= 4; l++) begin
        if (lat_busy[l] === 1'b1) begin
          bcnt[l]++;
          if (lat_addr[l] !== 8'h00 || lat_rd[l] !== 1'b0) addr_bad = 1'b1;
        end
        if (lat_valid[l] === 1'b1) begin
          vcnt[l]++;
          if (vedge[l] == 0) vedge[l] = k;
        end
      end
    end
    for (int l = 1; l <= 4; l++) begin
      vectors++; if (vedge[l] !== 1 + l || vcnt[l] !== 1) begin miscompares++; $display("FAIL lat%0d_valid: got edge %0d pulses %0d expected %0d 1", l, vedge[l], vcnt[l], 1 + l); end
      vectors++; if (bcnt[l] !== 1 + l) begin miscompares++; $display("FAIL lat%0d_busy: got %0d cycles expected %0d", l, bcnt[l], 1 + l); end
      vectors++; if (lat_ir[l] !== 16'hD105 || lat_pc[l] !== 8'h01) begin miscompares++; $display("FAIL lat%0d_ir: got ir %h pc %h expected d105 01", l, lat_ir[l], lat_pc[l]); end
    end
    vectors++; if (addr_bad !== 1'b0) begin miscompares++; $display("FAIL lat_addr_stable: got unstable expected stable"); end
  endtask

  task automatic test_reset_mid_wait;
    logic seen;
    seen = 1'b0;
    @(negedge clk); lat_fetch = 1'b1;
    @(posedge clk); #1; lat_fetch = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    vectors++; if (lat_busy[3] !== 1'b1) begin miscompares++; $display("FAIL midwait_busy: got %b expected 1", lat_busy[3]); end
    #2 lat_reset = 1'b0;
    #1;
    vectors++; if ({lat_busy[3], lat_valid[3], lat_rd[3], lat_halted[3]} !== 4'b0000) begin
      miscompares++; $display("FAIL midwait_flags: got %b expected 0000", {lat_busy[3], lat_valid[3], lat_rd[3], lat_halted[3]}); end
    vectors++; if (lat_pc[3] !== 8'h00 || lat_ir[3] !== 16'h0000) begin miscompares++; $display("FAIL midwait_regs: got pc %h ir %h expected 00 0000", lat_pc[3], lat_ir[3]); end
    repeat (2) @(negedge clk);
    lat_reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (lat_valid[3] === 1'b1 || lat_ir[3] !== 16'h0000) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0 || lat_pc[3] !== 8'h00) begin miscompares++; $display("FAIL midwait_after: got stray update %b pc %h expected 0 00", seen, lat_pc[3]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'hA000 | 16'(i);
    ram[0] = 16'hD105;
    ram[1] = 16'hD203;
    bus.fetch = 1'b0; bus.branch = 1'b0; bus.branch_abs = 1'b0; bus.target = 8'h00;
    bus.offset = 8'h00; bus.halt = 1'b0; bus.msel = 1'b0; bus.data_addr = 8'h00;
    test_reset;
    test_seq_fetch;
    test_branch;
    test_busy_ignore;
    test_msel;
    test_halt;
    test_latency;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
